// File: rtl/lcd_bus_decoder.sv
// Receiving end of an HD44780-style character-LCD bus: synchronises the bus, decodes
// each write latched on the falling edge of lcd_e, shadows controller state and mirrors visible characters.
module lcd_bus_decoder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_char,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t      r_state;
  logic [10:0] r_sync [SYNC_STAGES];
  logic        r_e_prev;
  logic        r_fall;
  logic        r_rs_cap;
  logic        r_rw_cap;
  logic [7:0]  r_data_cap;
  logic        r_cgram;

  logic [10:0] w_bus_in;
  logic [10:0] w_sync;
  logic        w_in_window;
  logic [4:0]  w_win_addr;

  assign w_bus_in = {lcd_e, lcd_rs, lcd_rw, lcd_data};
  assign w_sync   = r_sync[SYNC_STAGES-1];

  // Visible window is 0x00-0x0F (line 0) and 0x40-0x4F (line 1); bit 6 picks the line.
  assign w_in_window = (cursor_addr[5:4] == 2'b00);
  assign w_win_addr  = {cursor_addr[6], cursor_addr[3:0]};

  // Next legal DDRAM address on the 2-line map; off-map addresses snap to the next legal one.
  function automatic logic [6:0] f_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a >= 7'h67) return 7'h00;
      if (a >= 7'h27 && a <= 7'h3F) return 7'h40;
      return a + 7'd1;
    end
    if (a == 7'h00 || a >= 7'h68) return 7'h67;
    if (a >= 7'h28 && a <= 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  // NOTE: the sync chain is reset to zero so that lcd_e idling high after reset reads as a
  // rising edge, never a phantom fall; every bus bit shares the same chain depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_e_prev   <= 1'b0;
      r_fall     <= 1'b0;
      r_rs_cap   <= 1'b0;
      r_rw_cap   <= 1'b0;
      r_data_cap <= '0;
    end else begin
      r_sync[0] <= w_bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_e_prev   <= w_sync[10];
      r_fall     <= r_e_prev & ~w_sync[10];
      r_rs_cap   <= w_sync[9];
      r_rw_cap   <= w_sync[8];
      r_data_cap <= w_sync[7:0];
    end
  end

  // NOTE: all state and outputs use non-blocking assignments, so every branch below reads
  // the pre-edge values of cursor_addr, wr_addr and entry_inc.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cgram     <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_char     <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cursor_addr <= '0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      entry_inc   <= 1'b1;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      cmd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_fall && !r_rw_cap) begin
            if (!r_rs_cap) begin
              cmd_valid <= 1'b1;
              cmd_code  <= r_data_cap;
              priority casez (r_data_cap)
                8'b1???????: begin
                  cursor_addr <= r_data_cap[6:0];
                  r_cgram     <= 1'b0;
                end
                8'b01??????: r_cgram <= 1'b1;
                8'b001?????: begin end
                8'b0001????: begin
                  if (!r_data_cap[3]) cursor_addr <= f_step(cursor_addr, r_data_cap[2]);
                end
                8'b00001???: begin
                  disp_on   <= r_data_cap[2];
                  cursor_on <= r_data_cap[1];
                  blink_on  <= r_data_cap[0];
                end
                8'b000001??: entry_inc <= r_data_cap[1];
                8'b0000001?: cursor_addr <= '0;
                8'b00000001: begin
                  r_state <= S_CLEAR;
                  busy    <= 1'b1;
                  wr_en   <= 1'b1;
                  wr_addr <= '0;
                  wr_char <= CLEAR_CHAR;
                end
                default: begin end
              endcase
            end else if (!r_cgram) begin
              if (w_in_window) begin
                wr_en   <= 1'b1;
                wr_addr <= w_win_addr;
                wr_char <= r_data_cap;
              end
              cursor_addr <= f_step(cursor_addr, entry_inc);
            end
          end
        end
        S_CLEAR: begin
          if (r_fall && !r_rw_cap) overrun <= 1'b1;
          // wr_addr doubles as the sweep counter; cell 31 was written on the previous edge.
          if (wr_addr == 5'd31) begin
            r_state     <= S_IDLE;
            busy        <= 1'b0;
            cursor_addr <= '0;
            entry_inc   <= 1'b1;
            r_cgram     <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= wr_addr + 5'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Self-checking bench for lcd_bus_decoder: a transaction-level model is compared against the
// DUT every cycle, plus literal expectations for each directed bus transfer.
module tb_lcd_bus_decoder;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic       wr_en, cmd_valid, disp_on, cursor_on, blink_on, entry_inc, busy, overrun;
  logic [4:0] wr_addr;
  logic [7:0] wr_char, cmd_code;
  logic [6:0] cursor_addr;

  lcd_bus_decoder #(.SYNC_STAGES(SYNC), .CLEAR_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .cursor_addr(cursor_addr), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .entry_inc(entry_inc), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         p_cnt = 0;
  logic       p_rs, p_rw;
  logic [7:0] p_data;

  logic       m_ok = 1'b0;
  int         cyc = 0;
  int         m_clr_start;
  logic       m_wr_en, m_cmd_valid, m_disp, m_cur, m_blink, m_inc, m_busy, m_overrun, m_cgram;
  logic [4:0] m_wr_addr;
  logic [7:0] m_wr_char, m_cmd_code;
  logic [6:0] m_cursor;

  function automatic logic [6:0] m_next(input logic [6:0] a, input logic up);
    logic [6:0] n;
    n = a;
    for (int k = 0; k < 128; k++) begin
      n = up ? n + 7'd1 : n - 7'd1;
      if (n <= 7'h27 || (n >= 7'h40 && n <= 7'h67)) return n;
    end
    return n;
  endfunction

  task automatic m_apply(input logic was_busy);
    if (was_busy) begin
      m_overrun = 1'b1;
    end else if (!p_rs) begin
      m_cmd_valid = 1'b1;
      m_cmd_code  = p_data;
      if (p_data[7]) begin
        m_cursor = p_data[6:0];
        m_cgram  = 1'b0;
      end else if (p_data[6]) m_cgram = 1'b1;
      else if (p_data[5]) begin end
      else if (p_data[4]) begin
        if (!p_data[3]) m_cursor = m_next(m_cursor, p_data[2]);
      end else if (p_data[3]) begin
        m_disp = p_data[2]; m_cur = p_data[1]; m_blink = p_data[0];
      end else if (p_data[2]) m_inc = p_data[1];
      else if (p_data[1]) m_cursor = 7'h00;
      else if (p_data[0]) begin
        m_busy      = 1'b1;
        m_clr_start = cyc;
      end
    end else if (!m_cgram) begin
      if (m_cursor < 7'h10) begin
        m_wr_en = 1'b1; m_wr_addr = 5'(m_cursor); m_wr_char = p_data;
      end else if (m_cursor >= 7'h40 && m_cursor < 7'h50) begin
        m_wr_en = 1'b1; m_wr_addr = 5'(16 + int'(m_cursor) - 'h40); m_wr_char = p_data;
      end
      m_cursor = m_next(m_cursor, m_inc);
    end
  endtask

  always @(posedge clk) begin
    logic was_busy;
    m_wr_en     = 1'b0;
    m_cmd_valid = 1'b0;
    cyc++;
    if (rst) begin
      m_ok = 1'b1; p_cnt = 0;
      m_wr_addr = '0; m_wr_char = '0; m_cmd_code = '0; m_cursor = '0;
      m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0; m_inc = 1'b1;
      m_busy = 1'b0; m_overrun = 1'b0; m_cgram = 1'b0;
    end else begin
      was_busy = m_busy;
      if (p_cnt > 0) begin
        p_cnt--;
        if (p_cnt == 0 && !p_rw) m_apply(was_busy);
      end
      if (m_busy) begin
        if (cyc - m_clr_start < 32) begin
          m_wr_en = 1'b1; m_wr_addr = 5'(cyc - m_clr_start); m_wr_char = 8'h20;
        end else begin
          m_busy = 1'b0; m_cursor = 7'h00; m_inc = 1'b1; m_cgram = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_wr = 0, n_cmd = 0;
  always @(negedge clk) begin
    if (m_ok) begin
      check("wr_en", wr_en, m_wr_en);
      check("cmd_valid", cmd_valid, m_cmd_valid);
      check("cmd_code", cmd_code, m_cmd_code);
      check("cursor_addr", cursor_addr, m_cursor);
      check("flags", {disp_on, cursor_on, blink_on, entry_inc, busy, overrun},
            {m_disp, m_cur, m_blink, m_inc, m_busy, m_overrun});
      if (m_wr_en) begin
        check("wr_addr", wr_addr, m_wr_addr);
        check("wr_char", wr_char, m_wr_char);
      end
      if (wr_en === 1'b1) n_wr++;
      if (cmd_valid === 1'b1) n_cmd++;
    end
  end

  // ---------------- stimulus ----------------
  int         lat;
  logic [4:0] a;
  logic [7:0] c;

  // One bus cycle; returns edges from lcd_e fall to the first wr_en/cmd_valid (0 = none).
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d,
                      output int l, output logic [4:0] wa, output logic [7:0] wc);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    lcd_e = 1'b0;
    p_rs = rs; p_rw = rw; p_data = d; p_cnt = SYNC + 2;
    l = 0; wa = '0; wc = '0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (l == 0 && (wr_en === 1'b1 || cmd_valid === 1'b1)) begin
        l = n; wa = wr_addr; wc = wr_char;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int wr0, cmd0;
    rst = 1'b1; lcd_e = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_entry_inc", entry_inc, 1'b1);
    check("rst_cursor", cursor_addr, 7'h00);
    check("rst_no_strobes", n_wr + n_cmd, 0);

    cmd0 = n_cmd;
    xfer(1'b0, 1'b0, 8'h0E, lat, a, c);
    check("0E_latency", lat, SYNC + 2);
    check("0E_dcb", {disp_on, cursor_on, blink_on}, 3'b110);
    check("0E_code", cmd_code, 8'h0E);
    check("0E_once", n_cmd - cmd0, 1);

    xfer(1'b0, 1'b0, 8'hC0, lat, a, c);
    check("C0_cursor", cursor_addr, 7'h40);
    xfer(1'b1, 1'b0, 8'h41, lat, a, c);
    check("41_latency", lat, SYNC + 2);
    check("41_addr", a, 5'd16);
    check("41_char", c, 8'h41);
    check("41_cursor", cursor_addr, 7'h41);

    xfer(1'b0, 1'b0, 8'hA7, lat, a, c);
    xfer(1'b1, 1'b0, 8'h30, lat, a, c);
    check("27_no_write", lat, 0);
    check("27_wrap_inc", cursor_addr, 7'h40);

    xfer(1'b0, 1'b0, 8'h80, lat, a, c);
    xfer(1'b0, 1'b0, 8'h04, lat, a, c);
    xfer(1'b1, 1'b0, 8'h31, lat, a, c);
    check("31_addr", a, 5'd0);
    check("31_char", c, 8'h31);
    check("00_wrap_dec", cursor_addr, 7'h67);

    xfer(1'b0, 1'b0, 8'h14, lat, a, c);
    check("shift_right_wrap", cursor_addr, 7'h00);
    xfer(1'b0, 1'b0, 8'h10, lat, a, c);
    check("shift_left_wrap", cursor_addr, 7'h67);
    xfer(1'b0, 1'b0, 8'h1C, lat, a, c);
    check("display_shift_hold", cursor_addr, 7'h67);
    xfer(1'b0, 1'b0, 8'h06, lat, a, c);
    check("entry_inc_set", entry_inc, 1'b1);

    xfer(1'b0, 1'b0, 8'h48, lat, a, c);
    xfer(1'b1, 1'b0, 8'h55, lat, a, c);
    check("cgram_no_write", lat, 0);
    check("cgram_cursor_hold", cursor_addr, 7'h67);

    xfer(1'b0, 1'b0, 8'hB0, lat, a, c);
    xfer(1'b1, 1'b0, 8'h55, lat, a, c);
    check("offmap_no_write", lat, 0);
    check("offmap_step", cursor_addr, 7'h40);

    xfer(1'b0, 1'b0, 8'hCF, lat, a, c);
    xfer(1'b1, 1'b0, 8'h7E, lat, a, c);
    check("4F_addr", a, 5'd31);
    check("4F_cursor", cursor_addr, 7'h50);

    xfer(1'b0, 1'b0, 8'h02, lat, a, c);
    check("home", cursor_addr, 7'h00);
    xfer(1'b0, 1'b0, 8'h00, lat, a, c);
    check("nop_pulse", lat, SYNC + 2);

    cmd0 = n_cmd; wr0 = n_wr;
    xfer(1'b0, 1'b1, 8'h01, lat, a, c);
    xfer(1'b1, 1'b1, 8'h41, lat, a, c);
    xfer(1'b0, 1'b1, 8'h8A, lat, a, c);
    check("read_ignored", n_cmd - cmd0 + n_wr - wr0, 0);
    check("read_no_busy", {busy, overrun}, 2'b00);

    xfer(1'b0, 1'b0, 8'h04, lat, a, c);
    xfer(1'b0, 1'b0, 8'h85, lat, a, c);
    wr0 = n_wr;
    xfer(1'b0, 1'b0, 8'h01, lat, a, c);
    check("clear_latency", lat, SYNC + 2);
    check("clear_busy", busy, 1'b1);
    xfer(1'b1, 1'b0, 8'h77, lat, a, c);
    repeat (40) @(negedge clk);
    check("clear_count", n_wr - wr0, 32);
    check("clear_overrun", overrun, 1'b1);
    check("clear_done", busy, 1'b0);
    check("clear_cursor", cursor_addr, 7'h00);
    check("clear_entry_inc", entry_inc, 1'b1);

    xfer(1'b0, 1'b0, 8'h01, lat, a, c);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_overrun", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    xfer(1'b1, 1'b0, 8'h42, lat, a, c);
    check("post_rst_addr", a, 5'd0);
    check("post_rst_char", c, 8'h42);
    check("post_rst_cursor", cursor_addr, 7'h01);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
